// File: rtl/vertex_transform_pipe.sv
// Vertex transform: 4x4 fixed-point matrix, perspective divide, screen scale.
// Optional viewport offset (top-left origin) enabled by VT_VIEWPORT_OFFSET_EN.
module vertex_transform_pipe #(
  parameter int W      = 10,
  parameter int FRAC   = 0,
  parameter int HALF_W = 320,
  parameter int HALF_H = 240
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         mat_we,
  input  logic [3:0]   mat_addr,
  input  logic [W-1:0] mat_data,
  output logic         mat_ready,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic [W-1:0] w,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sx,
  output logic [W-1:0] sy,
  output logic         out_clip
);

  localparam int AW  = 2*W+2;
  localparam int CNW = $clog2(2*W);
  localparam logic signed [AW-1:0] SMAX = AW'((2**(W-1)) - 1);
  localparam logic signed [AW-1:0] SMIN = AW'(-(2**(W-1)));
  localparam logic signed [2*W-1:0] HW_N = (2*W)'(HALF_W);
  localparam logic signed [2*W-1:0] HH_N = (2*W)'(HALF_H);
  localparam logic signed [W-1:0] ONE  = W'(1 << FRAC);
  localparam logic signed [W-1:0] FOUR = W'(4 << FRAC);
  localparam logic signed [W-1:0] MONE = W'(-(1 << FRAC));
`ifdef VT_VIEWPORT_OFFSET_EN
  localparam logic signed [AW-1:0] HW_A = AW'(HALF_W);
  localparam logic signed [AW-1:0] HH_A = AW'(HALF_H);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_XFORM, S_SCALE, S_DIV, S_DONE
  } state_t;

  state_t r_st, w_nxt;

  logic signed [W-1:0] r_mat [16];
  logic signed [W-1:0] r_v [4];
  logic [1:0]          r_row;
  logic signed [W-1:0] r_cx, r_cy, r_cw;
  logic [CNW-1:0]      r_cnt;
  logic [2*W-1:0]      r_qx, r_qy;
  logic [W-1:0]        r_rx, r_ry, r_dv;
  logic                r_nx, r_ny, r_clipf;
  logic                r_rdy, r_ov, r_clip;
  logic [W-1:0]        r_sx, r_sy;

  logic signed [2*W-1:0] w_p [4];
  logic signed [AW-1:0]  w_acc, w_sh, w_sqx, w_sqy, w_fx, w_fy;
  logic signed [W-1:0]   w_row;
  logic signed [2*W-1:0] w_nx, w_ny;
  logic [2*W-1:0]        w_mx, w_my;
  logic [W:0]            w_tx, w_ty;
  logic [W-1:0]          w_dx, w_dy;
  logic                  w_gex, w_gey, w_clip;

  function automatic logic signed [W-1:0] sat(
    input logic signed [AW-1:0] v
  );
    if (v > SMAX) return SMAX[W-1:0];
    if (v < SMIN) return SMIN[W-1:0];
    return v[W-1:0];
  endfunction

  always_comb begin
    for (int c = 0; c < 4; c++) begin
      w_p[c] = (2*W)'(r_mat[{r_row, 2'(c)}])
             * (2*W)'(r_v[c]);
    end
    w_acc = AW'(w_p[0]) + AW'(w_p[1])
          + AW'(w_p[2]) + AW'(w_p[3]);
  end

  assign w_sh  = w_acc >>> FRAC;
  assign w_row = sat(w_sh);

  assign w_nx = (2*W)'(r_cx) * HW_N;
  assign w_ny = (2*W)'(r_cy) * HH_N;
  assign w_mx = w_nx[2*W-1] ? -w_nx : w_nx;
  assign w_my = w_ny[2*W-1] ? -w_ny : w_ny;
  assign w_clip = r_cw[W-1] || (r_cw == '0);

  // restoring step: remainder stays below |cw|, so W bits suffice
  assign w_tx  = {r_rx, r_qx[2*W-1]};
  assign w_ty  = {r_ry, r_qy[2*W-1]};
  assign w_gex = w_tx >= {1'b0, r_dv};
  assign w_gey = w_ty >= {1'b0, r_dv};
  assign w_dx  = w_tx[W-1:0] - r_dv;
  assign w_dy  = w_ty[W-1:0] - r_dv;

  assign w_sqx = r_nx ? -$signed({2'b00, r_qx})
                      : $signed({2'b00, r_qx});
  assign w_sqy = r_ny ? -$signed({2'b00, r_qy})
                      : $signed({2'b00, r_qy});
`ifdef VT_VIEWPORT_OFFSET_EN
  assign w_fx = HW_A + w_sqx;
  assign w_fy = HH_A - w_sqy;
`else
  assign w_fx = w_sqx;
  assign w_fy = w_sqy;
`endif

  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      S_IDLE:  if (in_valid) w_nxt = S_XFORM;
      S_XFORM: if (r_row == 2'd3) w_nxt = S_SCALE;
      S_SCALE: w_nxt = w_clip ? S_DONE : S_DIV;
      S_DIV:   if (r_cnt == CNW'(2*W-1)) w_nxt = S_DONE;
      S_DONE:  if (r_ov && out_ready) w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_st <= S_IDLE;
    else     r_st <= w_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) r_mat[i] <= '0;
      r_mat[0]  <= ONE;
      r_mat[3]  <= ONE;
      r_mat[5]  <= ONE;
      r_mat[7]  <= ONE;
      r_mat[10] <= MONE;
      r_mat[11] <= FOUR;
      r_mat[14] <= MONE;
      r_mat[15] <= FOUR;
      r_rdy  <= 1'b1;
      r_ov   <= 1'b0;
      r_clip <= 1'b0;
      r_sx   <= '0;
      r_sy   <= '0;
    end else begin
      r_rdy <= (w_nxt == S_IDLE);
      unique case (r_st)
        S_IDLE: begin
          if (mat_we) r_mat[mat_addr] <= mat_data;
          if (in_valid) begin
            r_v[0] <= x;
            r_v[1] <= y;
            r_v[2] <= z;
            r_v[3] <= w;
            r_row  <= 2'd0;
          end
        end
        S_XFORM: begin
          r_row <= r_row + 2'd1;
          if (r_row == 2'd0) r_cx <= w_row;
          if (r_row == 2'd1) r_cy <= w_row;
          if (r_row == 2'd3) r_cw <= w_row;
        end
        S_SCALE: begin
          r_nx    <= w_nx[2*W-1];
          r_ny    <= w_ny[2*W-1];
          r_qx    <= w_mx;
          r_qy    <= w_my;
          r_rx    <= '0;
          r_ry    <= '0;
          r_dv    <= r_cw;
          r_cnt   <= '0;
          r_clipf <= w_clip;
        end
        S_DIV: begin
          r_cnt <= r_cnt + 1'b1;
          r_qx  <= {r_qx[2*W-2:0], w_gex};
          r_qy  <= {r_qy[2*W-2:0], w_gey};
          r_rx  <= w_gex ? w_dx : w_tx[W-1:0];
          r_ry  <= w_gey ? w_dy : w_ty[W-1:0];
        end
        S_DONE: begin
          if (!r_ov) begin
            r_ov   <= 1'b1;
            r_clip <= r_clipf;
            r_sx   <= r_clipf ? '0 : sat(w_fx);
            r_sy   <= r_clipf ? '0 : sat(w_fy);
          end else if (out_ready) begin
            r_ov <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mat_ready = r_rdy;
  assign in_ready  = r_rdy;
  assign out_valid = r_ov;
  assign out_clip  = r_clip;
  assign sx        = r_sx;
  assign sy        = r_sy;

endmodule
